// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands one CHUNK-bit
// slice per clock from the MSB end, with signed mode and l/e/g cascade inputs.
module seq_magnitude_comparator #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             l_q, e_q, g_q;
  logic [WIDTH-1:0] msb_flip;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic             slice_ne;
  logic             accept;
  logic             decide;

  // Flipping the operand MSB at latch time turns a two's-complement compare into
  // an unsigned one; only the top slice is affected.
  always_comb begin
    msb_flip            = '0;
    msb_flip[WIDTH-1]   = sgn;
  end

  assign a_sl     = a_q[int'(idx)*CHUNK +: CHUNK];
  assign b_sl     = b_q[int'(idx)*CHUNK +: CHUNK];
  assign slice_ne = (a_sl != b_sl);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    decide  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_CMP;
        end
      end
      S_CMP: begin
        if (slice_ne || idx == '0) begin
          decide  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        if (start) begin
          accept  = 1'b1;
          state_n = S_CMP;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_CMP);
  assign done = (state == S_DONE);

  // NOTE: control state uses a synchronous reset with non-blocking assignments;
  // results are held until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx <= IDX_W'(NCHUNK - 1);
        lt  <= 1'b0;
        eq  <= 1'b0;
        gt  <= 1'b0;
      end else if (decide) begin
        if (slice_ne) begin
          gt <= (a_sl > b_sl);
          lt <= !(a_sl > b_sl);
          eq <= 1'b0;
        end else begin
          lt <= l_q;
          eq <= e_q;
          gt <= g_q;
        end
      end else if (state == S_CMP) begin
        idx <= idx - 1'b1;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a ^ msb_flip;
      b_q <= b ^ msb_flip;
      l_q <= l;
      e_q <= e;
      g_q <= g;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator: directed table, control
// hazard sequences, a single-slice instance and randomized model comparison.
module tb_seq_magnitude_comparator;

  localparam int W = 12;
  localparam int C = 3;
  localparam int N = W / C;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn, l, e, g;
    logic         lt, eq, gt;
    int           lat;
  } vec_t;

  logic         clk, rst, start, sgn, l, e, g;
  logic [W-1:0] a, b;
  logic         busy, done, lt, eq, gt;

  logic         start3, sgn3;
  logic [2:0]   a3, b3;
  logic         busy3, done3, lt3, eq3, gt3;

  int n_checks = 0;
  int n_errors = 0;

  seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sgn(sgn),
    .l(l), .e(e), .g(g), .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  seq_magnitude_comparator #(.WIDTH(3), .CHUNK(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .sgn(sgn3),
    .l(1'b0), .e(1'b0), .g(1'b0), .busy(busy3), .done(done3), .lt(lt3), .eq(eq3), .gt(gt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic vs, input logic vl, input logic ve, input logic vg,
                              input logic xl, input logic xe, input logic xg, input int lat);
    vec_t v;
    v.a = va; v.b = vb; v.sgn = vs; v.l = vl; v.e = ve; v.g = vg;
    v.lt = xl; v.eq = xe; v.gt = xg; v.lat = lat;
    return v;
  endfunction

  // Reference: integer compare, latency from the highest differing bit's slice.
  function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vs, input logic vl, input logic ve, input logic vg);
    vec_t         v;
    logic [W-1:0] d;
    int           h, sa, sb;
    v = mk(va, vb, vs, vl, ve, vg, 1'b0, 1'b0, 1'b0, 0);
    d = va ^ vb;
    if (d == '0) begin
      v.lat = N;
      v.lt = vl; v.eq = ve; v.gt = vg;
    end else begin
      h = 0;
      for (int i = 0; i < W; i++) if (d[i]) h = i;
      v.lat = N - h / C;
      sa = int'(va);
      sb = int'(vb);
      if (vs) begin
        if (va[W-1]) sa = sa - (1 << W);
        if (vb[W-1]) sb = sb - (1 << W);
      end
      v.gt = (sa > sb);
      v.lt = (sa < sb);
      v.eq = 1'b0;
    end
    return v;
  endfunction

  task automatic launch(input vec_t v);
    a = v.a; b = v.b; sgn = v.sgn; l = v.l; e = v.e; g = v.g;
    start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
    l = 1'($urandom); e = 1'($urandom); g = 1'($urandom);
    check("launch_busy", busy, 1);
    check("launch_done", done, 0);
    check("launch_clear", {lt, eq, gt}, 0);
  endtask

  // Waits for done; start is held high for the first 'poke' CMP edges.
  task automatic finish_op(input vec_t v, input int poke);
    int cycles   = 0;
    int busy_cnt = 0;
    while (!done && cycles < N + 4) begin
      if (busy) busy_cnt++;
      start = (cycles < poke);
      if (cycles < poke) begin
        a = W'($urandom); b = W'($urandom);
      end
      step();
      cycles++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("busy_in_done", busy, 0);
    check("latency", cycles, v.lat);
    check("busy_cycles", busy_cnt, v.lat);
    check("lt", lt, v.lt);
    check("eq", eq, v.eq);
    check("gt", gt, v.gt);
  endtask

  task automatic idle_after(input vec_t v);
    start = 1'b0;
    step();
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("hold", {lt, eq, gt}, {v.lt, v.eq, v.gt});
  endtask

  vec_t tbl[12];
  vec_t v, v2;

  initial begin
    tbl[0]  = mk(12'h800, 12'h7FF, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[1]  = mk(12'h123, 12'h124, 0, 0, 0, 0, 1, 0, 0, 4);
    tbl[2]  = mk(12'h800, 12'h001, 1, 0, 0, 0, 1, 0, 0, 1);
    tbl[3]  = mk(12'h800, 12'h001, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(12'hFFF, 12'hFFE, 1, 0, 0, 0, 0, 0, 1, 4);
    tbl[5]  = mk(12'h5A5, 12'h5A5, 0, 0, 1, 0, 0, 1, 0, 4);
    tbl[6]  = mk(12'h5A5, 12'h5A5, 0, 0, 0, 1, 0, 0, 1, 4);
    tbl[7]  = mk(12'h5A5, 12'h5A5, 0, 1, 0, 0, 1, 0, 0, 4);
    tbl[8]  = mk(12'h5A5, 12'h5A5, 1, 0, 0, 0, 0, 0, 0, 4);
    tbl[9]  = mk(12'h5A5, 12'h5A5, 0, 1, 1, 1, 1, 1, 1, 4);
    tbl[10] = mk(12'h000, 12'hFFF, 1, 0, 0, 0, 0, 0, 1, 1);
    tbl[11] = mk(12'h040, 12'h038, 0, 0, 0, 0, 0, 0, 1, 2);

    // Reset held with start asserted.
    rst = 1'b1; start = 1'b1; a = 12'h800; b = 12'h001; sgn = 1'b0;
    l = 1'b0; e = 1'b0; g = 1'b0;
    start3 = 1'b1; a3 = 3'd5; b3 = 3'd2; sgn3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_outputs", {busy, done, lt, eq, gt}, 0);
      check("rst_outputs3", {busy3, done3, lt3, eq3, gt3}, 0);
    end
    rst = 1'b0; start = 1'b0; start3 = 1'b0;
    step();
    check("post_rst_idle", {busy, done}, 0);

    foreach (tbl[i]) begin
      launch(tbl[i]);
      finish_op(tbl[i], 0);
      idle_after(tbl[i]);
    end

    // start with new operands during CMP is ignored.
    v = tbl[1];
    launch(v);
    finish_op(v, 2);
    idle_after(v);

    // Reset in the second CMP cycle aborts with no done.
    v = tbl[0];
    launch(v); finish_op(v, 0); idle_after(v);
    launch(tbl[1]);
    step();
    check("abort_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_outputs", {busy, done, lt, eq, gt}, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_done", {busy, done}, 0);
    end

    // Back-to-back: start in the done cycle.
    v  = tbl[0];
    v2 = tbl[1];
    launch(v);
    finish_op(v, 0);
    launch(v2);
    finish_op(v2, 0);
    idle_after(v2);

    // Single-slice instance.
    a3 = 3'd5; b3 = 3'd2; sgn3 = 1'b0; start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("w3_busy", busy3, 1);
    step();
    check("w3_done", done3, 1);
    check("w3_result", {lt3, eq3, gt3}, 3'b001);
    step();
    check("w3_done_pulse", done3, 0);
    a3 = 3'd5; b3 = 3'd2; sgn3 = 1'b1; start3 = 1'b1;
    step();
    start3 = 1'b0;
    step();
    check("w3_signed_done", done3, 1);
    check("w3_signed_result", {lt3, eq3, gt3}, 3'b100);

    // Randomized operations against the reference model, sometimes back-to-back.
    start = 1'b0;
    step();
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      v = model(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      launch(v);
      finish_op(v, (v.lat > 1) ? int'($urandom_range(0, v.lat - 1)) : 0);
      if ($urandom_range(0, 2) != 0) idle_after(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator for wide operands. It latches two `WIDTH`-bit operands and compares them one `CHUNK`-bit slice per clock, starting at the most significant slice and stopping at the first slice that differs. It adds a signed mode and a start/busy/done handshake. Cascade inputs `l`/`e`/`g` decide the result when every slice is equal, so instances chain the same way as the 3-bit combinational comparator.

## Interface
Parameters:
- `WIDTH`, 12: operand width in bits. Must be an integer multiple of `CHUNK`.
- `CHUNK`, 3: slice width compared per cycle; must be ≥1. Derived value `NCHUNK = WIDTH/CHUNK`.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a comparison. Accepted only in IDLE or DONE.
- `a`, in, WIDTH: operand A, sampled on the accepting edge.
- `b`, in, WIDTH: operand B, sampled on the accepting edge.
- `sgn`, in, 1: 1 = two's-complement compare, 0 = unsigned. Sampled with the operands.
- `l`, `e`, `g`, in, 1 each: cascade less/equal/greater from a less-significant stage. Sampled with the operands.
- `busy`, out, 1: high while in CMP.
- `done`, out, 1: one-cycle pulse when the result becomes valid.
- `lt`, `eq`, `gt`, out, 1 each: registered result. Held from `done` until the next accepted `start`.

## Operation
- State machine has three states: IDLE, CMP, DONE.
- **IDLE** + `start` → CMP:
  - latch `a`, `b`, `sgn`, `l`, `e`, `g`;
  - set slice index `idx = NCHUNK-1`;
  - clear `lt`, `eq`, `gt`.
- **CMP**, each cycle, compare slice `a[idx*CHUNK +: CHUNK]` against the same slice of `b`:
  - Signed mode: the operand MSB is inverted before comparing (offset-binary), in slice `NCHUNK-1` only.
  - Slices unequal → set `gt` = (A slice > B slice), `lt` = !`gt`, `eq` = 0; go to DONE.
  - Slices equal and `idx == 0` → set `lt`/`eq`/`gt` = the latched `l`/`e`/`g`, passed through unmodified (not forced one-hot); go to DONE.
  - Slices equal and `idx > 0` → `idx--`, stay in CMP.
- **DONE**: `done` = 1 for this single cycle.
  - `start` = 1 → accepted exactly as from IDLE (back-to-back operation).
  - otherwise → IDLE.
- `start` in CMP is ignored; the latched operands are unaffected.
- `WIDTH == CHUNK` is legal: a single slice, which is always the decisive one.

## Timing
- Reset (edge with `rst` = 1): state = IDLE, `idx` = 0, and all outputs 0 (`busy`, `done`, `lt`, `eq`, `gt`). Reset overrides `start`.
- Reset mid-CMP aborts the operation: no `done` pulse and results cleared.
- Latency: `start` sampled at edge E0, decisive slice evaluated at edge Ej (j = 1..`NCHUNK`).
  - `done`, `lt`, `eq`, `gt` are valid in the cycle after Ej.
  - Best case 1 cycle; worst case (all slices equal, or first difference in slice 0) `NCHUNK` cycles.
- `busy` is high from the cycle after E0 through the cycle ending at Ej; it is low while `done` is high.
- Back-to-back: `start` in the `done` cycle gives `busy` = 1 in the next cycle with no idle gap.
  - `lt`/`eq`/`gt` read 0 in that next cycle.
- `done` is never high for two consecutive cycles.
- Operand changes on `a`/`b` after the accepting edge have no effect.

## Test plan
Parameters `WIDTH` = 12, `CHUNK` = 3 unless stated.
1. Reset: hold `rst` = 1 for 2 cycles with `start` = 1 → `busy`, `done`, `lt`, `eq`, `gt` all 0 and no operation starts.
2. Early exit: unsigned, `a` = 0x800, `b` = 0x7FF → `done` in the cycle after E1, `gt` = 1, `lt` = `eq` = 0. `busy` high for exactly 1 cycle.
3. Late difference: unsigned, `a` = 0x123, `b` = 0x124 → slice 0 decides. `done` in the cycle after E4, `lt` = 1. `busy` high for 4 cycles.
4. Sign mode: `a` = 0x800, `b` = 0x001.
   - `sgn` = 1 → `lt` = 1 after 1 cycle.
   - Repeat with `sgn` = 0 → `gt` = 1.
   - `sgn` = 1, `a` = 0xFFF, `b` = 0xFFE → `gt` = 1 after 4 cycles.
5. Cascade: `a` = `b` = 0x5A5.
   - `l`, `e`, `g` = 0, 1, 0 → `eq` = 1 after 4 cycles.
   - `l`, `e`, `g` = 0, 0, 1 → `gt` = 1, `eq` = 0.
   - `l`, `e`, `g` = 1, 0, 0 → `lt` = 1.
6. Control hazards:
   - `start` with new operands during CMP → ignored; the original result is produced.
   - `rst` pulsed in the second CMP cycle → no `done`, IDLE, outputs 0.
   - `start` in the `done` cycle → new operation begins immediately with correct result.
   - `WIDTH` = 3, `CHUNK` = 3: `a` = 5, `b` = 2 → `gt` = 1 after 1 cycle.
